// File: rtl/seq_hit_pkg.sv
// Shared types and helpers for the sequence-hit logger.
// SEQ_HIT_LOGGER_TS_EN adds a 16-bit timestamp field to the event record.
package seq_hit_pkg;

  localparam int POS_W      = 3;
  localparam int FRAME_BITS = 8;
  localparam int CNT_BITS   = 16;
`ifdef SEQ_HIT_LOGGER_TS_EN
  localparam int TS_W       = 16;
`endif

  typedef struct packed {
    logic [FRAME_BITS-1:0] frame;
    logic [POS_W-1:0]      pos;
`ifdef SEQ_HIT_LOGGER_TS_EN
    logic [TS_W-1:0]       ts;
`endif
  } hit_evt_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seq_hit_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head output.
// The head register holds the last value read once the FIFO drains.
module seq_hit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = dout_q;

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    dout_d   = dout_q;
    // New head is either the word being written now or an already stored one.
    if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
      dout_d = din;
    end else if (rd_ptr_d != wr_ptr_d) begin
      dout_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/seq_hit_logger.sv
// Tags detector hits with frame index and bit position and queues them for a consumer.
// Define SEQ_HIT_LOGGER_TS_EN to add a cycle timestamp (ev_ts) to every event.
module seq_hit_logger
  import seq_hit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_W    = FRAME_BITS,
  parameter int CNT_W      = CNT_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sof,
  input  logic               hit,
  input  logic               clr,
  input  logic               ev_ready,
  output logic               ev_valid,
  output logic [FRAME_W-1:0] ev_frame,
  output logic [POS_W-1:0]   ev_pos,
  output logic [CNT_W-1:0]   hit_total,
  output logic               ovf
`ifdef SEQ_HIT_LOGGER_TS_EN
  ,
  output logic [TS_W-1:0]    ev_ts
`endif
);

  logic [POS_W-1:0]   pos_q, pos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]   hit_total_q, hit_total_d;
  logic               ovf_q, ovf_d;
  logic [POS_W-1:0]   cur_pos;
  logic [FRAME_W-1:0] cur_frame;
  logic               push, pop, drop;
  logic               fifo_full, fifo_empty;
  hit_evt_t           evt_in, evt_out;
`ifdef SEQ_HIT_LOGGER_TS_EN
  logic [TS_W-1:0]    ts_q, ts_d;
`endif

  always_comb begin
    cur_pos   = sof ? '0 : pos_q;
    // A SOF at slot 0 was already counted by the natural wrap.
    cur_frame = (sof && (pos_q != '0)) ? frame_q + 1'b1 : frame_q;
    pos_d     = pos_q;
    frame_d   = frame_q;
    if (en) begin
      pos_d   = cur_pos + 1'b1;
      frame_d = (cur_pos == 3'd7) ? cur_frame + 1'b1 : cur_frame;
    end

    push = en && hit;
    pop  = ev_valid && ev_ready;
    drop = push && fifo_full && !pop;

    evt_in       = '0;
    evt_in.frame = cur_frame;
    evt_in.pos   = cur_pos;
`ifdef SEQ_HIT_LOGGER_TS_EN
    evt_in.ts    = ts_q;
    ts_d         = ts_q + 1'b1;
`endif

    hit_total_d = clr ? '0 : hit_total_q;
    if (push) begin
      hit_total_d = sat_inc(hit_total_d);
    end
    ovf_d = (clr ? 1'b0 : ovf_q) || drop;
  end

  seq_hit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(hit_evt_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (evt_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (evt_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      frame_q     <= '0;
      hit_total_q <= '0;
      ovf_q       <= 1'b0;
`ifdef SEQ_HIT_LOGGER_TS_EN
      ts_q        <= '0;
`endif
    end else begin
      pos_q       <= pos_d;
      frame_q     <= frame_d;
      hit_total_q <= hit_total_d;
      ovf_q       <= ovf_d;
`ifdef SEQ_HIT_LOGGER_TS_EN
      ts_q        <= ts_d;
`endif
    end
  end

  assign ev_valid  = !fifo_empty;
  assign ev_frame  = evt_out.frame;
  assign ev_pos    = evt_out.pos;
  assign hit_total = hit_total_q;
  assign ovf       = ovf_q;
`ifdef SEQ_HIT_LOGGER_TS_EN
  assign ev_ts     = evt_out.ts;
`endif

endmodule

// File: tb/tb_seq_hit_logger.sv
// Randomized and directed bench for seq_hit_logger against a queue-based reference model.
// Honors SEQ_HIT_LOGGER_TS_EN for the optional timestamp output.
module tb_seq_hit_logger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, sof, hit, clr, ev_ready;
  logic        ev_valid;
  logic [7:0]  ev_frame;
  logic [2:0]  ev_pos;
  logic [15:0] hit_total;
  logic        ovf;
`ifdef SEQ_HIT_LOGGER_TS_EN
  logic [15:0] ev_ts;
`endif

  always #5 clk = ~clk;

  seq_hit_logger #(.FIFO_DEPTH(DEPTH), .FRAME_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sof       (sof),
    .hit       (hit),
    .clr       (clr),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_frame  (ev_frame),
    .ev_pos    (ev_pos),
    .hit_total (hit_total),
    .ovf       (ovf)
`ifdef SEQ_HIT_LOGGER_TS_EN
    ,
    .ev_ts     (ev_ts)
`endif
  );

  typedef struct {int frame; int pos; int ts;} ev_t;
  ev_t m_q[$];
  int  m_pos, m_frame, m_total, m_ovf, m_ts;
  int  n_checks = 0;
  int  n_bad    = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pos = 0; m_frame = 0; m_total = 0; m_ovf = 0; m_ts = 0;
  endfunction

  // Behaviour for one clock edge, using the inputs currently applied.
  task automatic model_step();
    int  cp, cf;
    bit  do_pop, do_push, was_full;
    ev_t e;
    cp = m_pos; cf = m_frame;
    if (sof) begin
      cp = 0;
      if (m_pos != 0) cf = (m_frame + 1) % 256;
    end
    do_pop   = (m_q.size() > 0) && ev_ready;
    do_push  = en && hit;
    was_full = (m_q.size() == DEPTH);
    if (clr) begin
      m_total = 0;
      m_ovf   = 0;
    end
    if (do_push) m_total = (m_total == 65535) ? 65535 : m_total + 1;
    if (do_pop) begin
      e = m_q.pop_front();
      $display("pop: frame=%0d pos=%0d ts=%0d total=%0d", e.frame, e.pos, e.ts, m_total);
    end
    if (do_push) begin
      if (was_full && !do_pop) m_ovf = 1;
      else m_q.push_back('{cf, cp, m_ts});
    end
    if (en) begin
      m_pos   = (cp + 1) % 8;
      m_frame = (cp == 7) ? (cf + 1) % 256 : cf;
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_outputs();
    check_val("ev_valid", int'(ev_valid), int'(m_q.size() > 0));
    check_val("hit_total", int'(hit_total), m_total);
    check_val("ovf", int'(ovf), m_ovf);
    if (m_q.size() > 0) begin
      check_val("ev_frame", int'(ev_frame), m_q[0].frame);
      check_val("ev_pos", int'(ev_pos), m_q[0].pos);
`ifdef SEQ_HIT_LOGGER_TS_EN
      check_val("ev_ts", int'(ev_ts), m_q[0].ts);
`endif
    end
  endtask

  task automatic drive(input bit e, input bit s, input bit h, input bit c, input bit r);
    en = e; sof = s; hit = h; clr = c; ev_ready = r;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    en = 0; sof = 0; hit = 0; clr = 0; ev_ready = 0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_valid", int'(ev_valid), 0);
    check_val("rst_frame", int'(ev_frame), 0);
    check_val("rst_pos", int'(ev_pos), 0);
    check_val("rst_total", int'(hit_total), 0);
    check_val("rst_ovf", int'(ovf), 0);
    @(posedge clk);
    #2;
    check_val("rst_hold_valid", int'(ev_valid), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int rdy_pct;
    rst_n = 1'b0;
    do_reset();

    // Hits at slots 3 and 10 of a stream starting with SOF.
    for (int s = 0; s < 16; s++) begin
      drive(1, s == 0, (s == 3) || (s == 10), 0, 1);
      if (s == 3) begin
        check_val("s1_valid_a", int'(ev_valid), 1);
        check_val("s1_frame_a", int'(ev_frame), 0);
        check_val("s1_pos_a", int'(ev_pos), 3);
      end
      if (s == 10) begin
        check_val("s1_valid_b", int'(ev_valid), 1);
        check_val("s1_frame_b", int'(ev_frame), 1);
        check_val("s1_pos_b", int'(ev_pos), 2);
      end
    end
    check_val("s1_total", int'(hit_total), 2);

    // Five hits with the consumer stalled: one dropped.
    do_reset();
    repeat (5) drive(1, 0, 1, 0, 0);
    check_val("s2_ovf", int'(ovf), 1);
    check_val("s2_total", int'(hit_total), 5);
    repeat (5) drive(0, 0, 0, 0, 1);
    check_val("s2_drained", int'(ev_valid), 0);

    // Full FIFO with simultaneous push and pop: no overflow.
    drive(0, 0, 0, 1, 0);
    check_val("s3_clr_ovf", int'(ovf), 0);
    check_val("s3_clr_total", int'(hit_total), 0);
    repeat (4) drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 1);
    check_val("s3_ovf", int'(ovf), 0);
    check_val("s3_total", int'(hit_total), 5);
    repeat (5) drive(0, 0, 0, 0, 1);

    // Mid-frame SOF at pos 5 of frame 2.
    do_reset();
    drive(1, 1, 0, 0, 1);
    repeat (20) drive(1, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 1);
    check_val("s4_frame", int'(ev_frame), 3);
    check_val("s4_pos", int'(ev_pos), 0);
    repeat (7) drive(1, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 1);
    check_val("s4_wrap_frame", int'(ev_frame), 4);
    check_val("s4_wrap_pos", int'(ev_pos), 0);
    drive(0, 0, 0, 0, 1);

    // EN gating with HIT held high on disabled slots.
    do_reset();
    for (int i = 0; i < 16; i++) drive(i % 2 == 0, 0, (i % 2 == 1) || (i % 4 == 0), 0, 1);
    check_val("s5_total", int'(hit_total), 4);

    // CLR colliding with overflow, then reset with events queued.
    do_reset();
    repeat (4) drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0);
    check_val("s6_ovf", int'(ovf), 1);
    check_val("s6_total", int'(hit_total), 1);
    repeat (2) drive(0, 0, 0, 0, 1);
    do_reset();
    drive(1, 1, 1, 0, 0);
    check_val("s6_new_valid", int'(ev_valid), 1);
    check_val("s6_new_frame", int'(ev_frame), 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 1);

    // Random traffic with varying consumer throughput and occasional resets.
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) rdy_pct = $urandom_range(10, 90);
      if ($urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0,
            $urandom_range(0, 99) < rdy_pct);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
